// File: rtl/rv_pkg.sv
// Shared encodings for the rv_processor core: opcodes, funct fields, ALU
// operation set and the built-in default program.
package rv_pkg;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [31:0] DEFAULT_PROG [4] = '{
        32'hffff_f0b7, 32'h1234_5137, 32'h1234_5197, 32'hffff_f217
    };

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

endpackage

// File: rtl/rv_processor_regfile.sv
// 32x32 integer register file: two combinational read ports, one synchronous
// write port, asynchronous clear. x0 is hardwired to zero.
module register_file (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);

    logic [31:0] reg_array [0:31];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) begin
                reg_array[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            reg_array[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : reg_array[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : reg_array[i_raddr2];

endmodule

// File: rtl/rv_processor.sv
// Single-cycle RV32I subset core (LUI, AUIPC, OP-IMM, OP) with built-in ROM.
// One instruction retires per rising edge; unsupported encodings act as NOPs.
module rv_processor
    import rv_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter string       IMEM_INIT  = "",
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clk,
    input logic rst_n
);

    localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    function automatic logic [IMEM_DEPTH-1:0][31:0] rom_load();
        logic [31:0]                  mem [IMEM_DEPTH];
        logic [IMEM_DEPTH-1:0][31:0]  packed_rom;
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            mem[i] = NOP_INSTR;
        end
        if (IMEM_INIT == "") begin
            for (int i = 0; i < 4; i++) begin
                if (i < IMEM_DEPTH) mem[i] = DEFAULT_PROG[i];
            end
        end
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            packed_rom[i] = mem[i];
        end
        return packed_rom;
    endfunction

    logic [IMEM_DEPTH-1:0][31:0] r_rom = rom_load();
    logic [31:0]                 r_pc;

    logic [29:0]   w_word;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_instr;
    logic [6:0]    w_opcode;
    logic [4:0]    w_rd;
    logic [4:0]    w_rs1;
    logic [4:0]    w_rs2;
    logic [2:0]    w_funct3;
    logic [6:0]    w_funct7;
    logic [31:0]   w_imm_i;
    logic [31:0]   w_imm_u;
    logic [31:0]   w_rs1_val;
    logic [31:0]   w_rs2_val;
    logic [31:0]   w_a;
    logic [31:0]   w_b;
    logic [31:0]   w_result;
    logic          w_we;
    alu_op_t       w_alu_op;

    // Word index wraps modulo the ROM depth, which need not be a power of two.
    assign w_word  = r_pc[31:2] % 30'(IMEM_DEPTH);
    assign w_idx   = w_word[AW-1:0];
    assign w_instr = r_rom[w_idx];

    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_funct3 = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_funct7 = w_instr[31:25];
    assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_u  = {w_instr[31:12], 12'b0};

    always_comb begin
        w_we     = 1'b0;
        w_alu_op = ALU_ADD;
        w_a      = w_rs1_val;
        w_b      = w_rs2_val;
        case (w_opcode)
            OPC_LUI: begin
                w_we = 1'b1;
                w_a  = 32'd0;
                w_b  = w_imm_u;
            end
            OPC_AUIPC: begin
                w_we = 1'b1;
                w_a  = r_pc;
                w_b  = w_imm_u;
            end
            OPC_OPIMM: begin
                w_b  = w_imm_i;
                w_we = 1'b1;
                case (w_funct3)
                    F3_ADD_SUB: w_alu_op = ALU_ADD;
                    F3_SLT:     w_alu_op = ALU_SLT;
                    F3_SLTU:    w_alu_op = ALU_SLTU;
                    F3_XOR:     w_alu_op = ALU_XOR;
                    F3_OR:      w_alu_op = ALU_OR;
                    F3_AND:     w_alu_op = ALU_AND;
                    F3_SLL: begin
                        w_alu_op = ALU_SLL;
                        w_we     = (w_funct7 == F7_BASE);
                    end
                    default: begin
                        // Shift-right immediates: funct7 selects logical vs arithmetic.
                        w_alu_op = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        w_we     = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                if (w_funct7 == F7_BASE) begin
                    w_we = 1'b1;
                    case (w_funct3)
                        F3_ADD_SUB: w_alu_op = ALU_ADD;
                        F3_SLL:     w_alu_op = ALU_SLL;
                        F3_SLT:     w_alu_op = ALU_SLT;
                        F3_SLTU:    w_alu_op = ALU_SLTU;
                        F3_XOR:     w_alu_op = ALU_XOR;
                        F3_SR:      w_alu_op = ALU_SRL;
                        F3_OR:      w_alu_op = ALU_OR;
                        default:    w_alu_op = ALU_AND;
                    endcase
                end else if (w_funct7 == F7_ALT) begin
                    if (w_funct3 == F3_ADD_SUB) begin
                        w_we     = 1'b1;
                        w_alu_op = ALU_SUB;
                    end else if (w_funct3 == F3_SR) begin
                        w_we     = 1'b1;
                        w_alu_op = ALU_SRA;
                    end
                end
            end
            default: w_we = 1'b0;
        endcase
    end

    always_comb begin
        w_result = 32'd0;
        case (w_alu_op)
            ALU_ADD:  w_result = w_a + w_b;
            ALU_SUB:  w_result = w_a - w_b;
            ALU_SLL:  w_result = w_a << w_b[4:0];
            ALU_SLT:  w_result = {31'd0, $signed(w_a) < $signed(w_b)};
            ALU_SLTU: w_result = {31'd0, w_a < w_b};
            ALU_XOR:  w_result = w_a ^ w_b;
            ALU_SRL:  w_result = w_a >> w_b[4:0];
            ALU_SRA:  w_result = 32'($signed(w_a) >>> w_b[4:0]);
            ALU_OR:   w_result = w_a | w_b;
            ALU_AND:  w_result = w_a & w_b;
            default:  w_result = 32'd0;
        endcase
    end

    register_file regs (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rs1_val),
        .o_rdata2 (w_rs2_val),
        .i_we     (w_we),
        .i_waddr  (w_rd),
        .i_wdata  (w_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= r_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_rv_processor.sv
// Directed bench for rv_processor: loads small programs into the ROM, clocks
// one edge per instruction and checks register-file state against hand values.
module tb_rv_processor;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] prog_q[$];

    rv_processor #(.IMEM_DEPTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_reg(input int k);
        return dut.regs.reg_array[k];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Holds reset while the ROM is rewritten, then releases on a falling edge.
    task automatic load_prog();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) dut.r_rom[i] = NOP;
        for (int i = 0; i < prog_q.size(); i++) dut.r_rom[i] = prog_q[i];
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        #12;
        check("reset_pc", dut.r_pc, 32'h0);
        for (int k = 0; k < 32; k++) check($sformatf("reset_x%0d", k), rd_reg(k), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default program: LUI/AUIPC
        tick(); check("dflt_x1", rd_reg(1), 32'hffff_f000);
        check("dflt_pc1", dut.r_pc, 32'h4);
        tick(); check("dflt_x2", rd_reg(2), 32'h1234_5000);
        tick(); check("dflt_x3", rd_reg(3), 32'h1234_5008);
        tick(); check("dflt_x4", rd_reg(4), 32'hffff_f00c);
        check("dflt_pc4", dut.r_pc, 32'h10);

        // Mid-program asynchronous reset
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        check("rst_pre_x1", rd_reg(1), 32'hffff_f000);
        check("rst_pre_x2", rd_reg(2), 32'h1234_5000);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_x1", rd_reg(1), 32'h0);
        check("rst_async_x2", rd_reg(2), 32'h0);
        check("rst_async_pc", dut.r_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_post_x1", rd_reg(1), 32'hffff_f000);
        check("rst_post_x2", rd_reg(2), 32'h0);

        // addi/sub plus sll/xori/andi
        prog_q = '{32'hfff0_0293, 32'h0022_8313, 32'h4050_03b3,
                   32'h0053_1733, 32'h0f02_c793, 32'h7ff7_f813};
        load_prog();
        tick(); check("addi_x5", rd_reg(5), 32'hffff_ffff);
        tick(); check("addi_x6", rd_reg(6), 32'h0000_0001);
        tick(); check("sub_x7", rd_reg(7), 32'h0000_0001);
        tick(); check("sll_x14", rd_reg(14), 32'h8000_0000);
        tick(); check("xori_x15", rd_reg(15), 32'hffff_ff0f);
        tick(); check("andi_x16", rd_reg(16), 32'h0000_070f);

        // Writes to x0 are dropped and x0 reads as zero
        prog_q = '{32'habcd_e037, 32'h0050_0013, 32'h0070_0693};
        load_prog();
        tick(); check("x0_lui", rd_reg(0), 32'h0);
        tick(); check("x0_addi", rd_reg(0), 32'h0);
        tick(); check("x0_src_x13", rd_reg(13), 32'h0000_0007);

        // Shifts and signed/unsigned compares
        prog_q = '{32'hff00_0413, 32'h4024_5493, 32'h01c4_5513,
                   32'h0004_25b3, 32'h0004_3633};
        load_prog();
        tick(); check("addi_x8", rd_reg(8), 32'hffff_fff0);
        tick(); check("srai_x9", rd_reg(9), 32'hffff_fffc);
        tick(); check("srli_x10", rd_reg(10), 32'h0000_000f);
        tick(); check("slt_x11", rd_reg(11), 32'h0000_0001);
        tick(); check("sltu_x12", rd_reg(12), 32'h0000_0000);

        // Illegal encoding retires as a NOP
        prog_q = '{32'hffff_ffff, 32'hffff_f0b7};
        load_prog();
        tick();
        check("illegal_x1", rd_reg(1), 32'h0);
        check("illegal_x31", rd_reg(31), 32'h0);
        check("illegal_pc", dut.r_pc, 32'h4);
        tick(); check("after_illegal_x1", rd_reg(1), 32'hffff_f000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
